// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types and default timing for the DRAM command-bus arbiter.
package bank_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } arb_cmd_t;

  localparam int DEF_NUM_BANKS = 8;
  localparam int DEF_BANK_W    = 3;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_T_RRD     = 4;
  localparam int DEF_T_FAW     = 20;
  localparam int DEF_T_CCD     = 4;
  localparam int DEF_T_WTR     = 6;
  localparam int DEF_T_RTW     = 8;
  localparam int DEF_T_RFC     = 100;

  // Reserved codes 6 and 7 collapse to NOP so they never win arbitration.
  function automatic arb_cmd_t decode_cmd(input logic [2:0] code);
    case (code)
      3'd1:    return CMD_ACT;
      3'd2:    return CMD_RD;
      3'd3:    return CMD_WR;
      3'd4:    return CMD_PRE;
      3'd5:    return CMD_REF;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_pick.sv
// Round-robin picker: first set bit of elig_i at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // N is a power of two, so W-bit addition wraps the search naturally.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_i + W'(k);
      if (!found_o && elig_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Command-bus arbiter for the per-bank FSMs; enforces inter-bank DRAM timing.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_W    = DEF_BANK_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_FAW     = DEF_T_FAW,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_WTR     = DEF_T_WTR,
  parameter int T_RTW     = DEF_T_RTW,
  parameter int T_RFC     = DEF_T_RFC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic [NUM_BANKS-1:0]   req,
  input  logic [3*NUM_BANKS-1:0] req_cmd,
  output logic [NUM_BANKS-1:0]   stall,
  output logic                   grant_valid,
  output logic [BANK_W-1:0]      grant_bank,
  output logic [2:0]             grant_cmd
);

  localparam logic [CNT_W-1:0] LD_RRD = (T_RRD > 1) ? CNT_W'(T_RRD - 1) : '0;
  localparam logic [CNT_W-1:0] LD_FAW = (T_FAW > 1) ? CNT_W'(T_FAW - 1) : '0;
  localparam logic [CNT_W-1:0] LD_CCD = (T_CCD > 1) ? CNT_W'(T_CCD - 1) : '0;
  localparam logic [CNT_W-1:0] LD_WTR = (T_WTR > 1) ? CNT_W'(T_WTR - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RTW = (T_RTW > 1) ? CNT_W'(T_RTW - 1) : '0;
  localparam logic [CNT_W-1:0] LD_RFC = (T_RFC > 1) ? CNT_W'(T_RFC - 1) : '0;

  logic [CNT_W-1:0]  cnt_rrd_q, cnt_rrd_d;
  logic [CNT_W-1:0]  cnt_ccd_q, cnt_ccd_d;
  logic [CNT_W-1:0]  cnt_wtr_q, cnt_wtr_d;
  logic [CNT_W-1:0]  cnt_rtw_q, cnt_rtw_d;
  logic [CNT_W-1:0]  cnt_rfc_q, cnt_rfc_d;
  logic [CNT_W-1:0]  faw_q [4];
  logic [CNT_W-1:0]  faw_d [4];
  logic [1:0]        faw_ptr_q, faw_ptr_d;
  logic [BANK_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_BANKS-1:0] ref_m, col_m, pre_m, act_m;
  logic rd_ok, wr_ok, act_ok;
  logic ref_found, col_found, pre_found, act_found;
  logic [BANK_W-1:0] ref_idx, col_idx, pre_idx, act_idx;
  arb_cmd_t gcmd;
  arb_cmd_t bank_cmd;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  assign rd_ok  = (cnt_ccd_q == '0) && (cnt_wtr_q == '0);
  assign wr_ok  = (cnt_ccd_q == '0) && (cnt_rtw_q == '0);
  assign act_ok = (cnt_rrd_q == '0) && (cnt_rfc_q == '0) && (faw_q[faw_ptr_q] == '0);

  always_comb begin
    ref_m    = '0;
    col_m    = '0;
    pre_m    = '0;
    act_m    = '0;
    bank_cmd = CMD_NOP;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_cmd = decode_cmd(req_cmd[3*i +: 3]);
      if (req[i]) begin
        ref_m[i] = (bank_cmd == CMD_REF);
        col_m[i] = ((bank_cmd == CMD_RD) && rd_ok) || ((bank_cmd == CMD_WR) && wr_ok);
        pre_m[i] = (bank_cmd == CMD_PRE);
        act_m[i] = (bank_cmd == CMD_ACT) && act_ok;
      end
    end
  end

  rr_pick #(.N(NUM_BANKS), .W(BANK_W)) u_pick_ref (
    .elig_i(ref_m), .ptr_i(rr_ptr_q), .found_o(ref_found), .idx_o(ref_idx));
  rr_pick #(.N(NUM_BANKS), .W(BANK_W)) u_pick_col (
    .elig_i(col_m), .ptr_i(rr_ptr_q), .found_o(col_found), .idx_o(col_idx));
  rr_pick #(.N(NUM_BANKS), .W(BANK_W)) u_pick_pre (
    .elig_i(pre_m), .ptr_i(rr_ptr_q), .found_o(pre_found), .idx_o(pre_idx));
  rr_pick #(.N(NUM_BANKS), .W(BANK_W)) u_pick_act (
    .elig_i(act_m), .ptr_i(rr_ptr_q), .found_o(act_found), .idx_o(act_idx));

  // Outputs are gated by rst_n too, so a bank never sees a grant during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_bank  = '0;
    gcmd        = CMD_NOP;
    if (rst_n && init_done) begin
      if (ref_found) begin
        grant_valid = 1'b1;
        grant_bank  = ref_idx;
        gcmd        = CMD_REF;
      end else if (col_found) begin
        grant_valid = 1'b1;
        grant_bank  = col_idx;
        gcmd        = decode_cmd(req_cmd[3*col_idx +: 3]);
      end else if (pre_found) begin
        grant_valid = 1'b1;
        grant_bank  = pre_idx;
        gcmd        = CMD_PRE;
      end else if (act_found) begin
        grant_valid = 1'b1;
        grant_bank  = act_idx;
        gcmd        = CMD_ACT;
      end
    end
    grant_cmd = gcmd;
    stall     = '1;
    if (grant_valid) stall[grant_bank] = 1'b0;
  end

  always_comb begin
    cnt_rrd_d = dec_sat(cnt_rrd_q);
    cnt_ccd_d = dec_sat(cnt_ccd_q);
    cnt_wtr_d = dec_sat(cnt_wtr_q);
    cnt_rtw_d = dec_sat(cnt_rtw_q);
    cnt_rfc_d = dec_sat(cnt_rfc_q);
    for (int unsigned j = 0; j < 4; j++) faw_d[j] = dec_sat(faw_q[j]);
    faw_ptr_d = faw_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = grant_bank + BANK_W'(1);
      case (gcmd)
        CMD_ACT: begin
          cnt_rrd_d        = LD_RRD;
          faw_d[faw_ptr_q] = LD_FAW;
          faw_ptr_d        = faw_ptr_q + 2'd1;
        end
        CMD_RD: begin
          cnt_ccd_d = LD_CCD;
          cnt_rtw_d = LD_RTW;
        end
        CMD_WR: begin
          cnt_ccd_d = LD_CCD;
          cnt_wtr_d = LD_WTR;
        end
        CMD_REF: cnt_rfc_d = LD_RFC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rrd_q <= '0;
      cnt_ccd_q <= '0;
      cnt_wtr_q <= '0;
      cnt_rtw_q <= '0;
      cnt_rfc_q <= '0;
      faw_q     <= '{default: '0};
      faw_ptr_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      cnt_rrd_q <= cnt_rrd_d;
      cnt_ccd_q <= cnt_ccd_d;
      cnt_wtr_q <= cnt_wtr_d;
      cnt_rtw_q <= cnt_rtw_d;
      cnt_rfc_q <= cnt_rfc_d;
      faw_q     <= faw_d;
      faw_ptr_q <= faw_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
- Shares the single DRAM command bus among the NUM_BANKS per-bank FSMs.
- Each bank FSM raises a request while in a *_CHECK state and waits for its stall to drop.
- Each cycle the arbiter picks at most one eligible request by class priority and round-robin, then deasserts that bank's stall.
- It enforces the inter-bank timing rules the bank FSMs cannot see locally: tRRD, tFAW, tCCD, tWTR, tRTW, tRFC.

Parameters:
- NUM_BANKS, 8: number of bank FSMs (power of two).
- BANK_W, 3: log2(NUM_BANKS).
- CNT_W, 8: width of every timing counter.
- T_RRD, 4: minimum cycles between ACT grants.
- T_FAW, 20: window in which at most 4 ACTs may be granted.
- T_CCD, 4: minimum cycles between column (RD/WR) grants.
- T_WTR, 6: minimum cycles from WR grant to RD grant.
- T_RTW, 8: minimum cycles from RD grant to WR grant.
- T_RFC, 100: minimum cycles from REF grant to any ACT grant.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- init_done, input, 1: main FSM has completed DRAM initialisation; grants are blocked while 0.
- req, input, NUM_BANKS: bank i requests the bus.
- req_cmd, input, 3*NUM_BANKS: arb_cmd_t of bank i, in slice [3i+2:3i].
- stall, output, NUM_BANKS: 0 only for the bank granted this cycle.
- grant_valid, output, 1: a grant is made this cycle.
- grant_bank, output, BANK_W: index of the granted bank.
- grant_cmd, output, 3: arb_cmd_t of the granted command.

Behaviour:
- Outputs are combinational from req/req_cmd/init_done and registered state (zero-cycle decision).
- All state elements reset asynchronously on rst_n low:
  - every timing counter = 0;
  - FAW ring = all 0;
  - round-robin pointer = 0.
- While rst_n=0 or init_done=0, outputs are forced: stall = all 1s, grant_valid=0, grant_bank=0, grant_cmd=CMD_NOP.
- arb_cmd_t encoding: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5; codes 6 and 7 are treated as NOP.
- A request with cmd NOP is ignored.
- Eligibility per command:
  - REF: always eligible.
  - PRE: always eligible.
  - RD: cnt_ccd==0 and cnt_wtr==0.
  - WR: cnt_ccd==0 and cnt_rtw==0.
  - ACT: cnt_rrd==0, cnt_rfc==0, and the oldest FAW ring entry ==0.
- Class priority: REF > RD/WR > PRE > ACT.
  - Within the highest class that has an eligible request, choose round-robin starting at rr_ptr; the index search wraps from NUM_BANKS-1 to 0.
- On a grant:
  - rr_ptr <= grant_bank+1, modulo NUM_BANKS;
  - stall[grant_bank]=0 for that cycle only; all other stall bits stay 1.
- Counter loads on a grant; the named cycle is the earliest cycle the follow-on command may be granted, for a grant at cycle t:
  - ACT: cnt_rrd <= T_RRD-1. The oldest FAW entry is replaced with T_FAW-1 and the ring pointer advances. A 5th ACT is therefore granted no earlier than t0+T_FAW, where t0 is the grant cycle of the 1st of the preceding 4 ACTs.
  - RD: cnt_ccd <= T_CCD-1; cnt_rtw <= T_RTW-1. The earliest next RD is t+T_CCD; the earliest WR is t+T_RTW.
  - WR: cnt_ccd <= T_CCD-1; cnt_wtr <= T_WTR-1.
  - REF: cnt_rfc <= T_RFC-1.
  - PRE: no counter change.
- Counters not loaded in a cycle decrement by 1 and saturate at 0, including all FAW entries.
- Parameter value 0 or 1 means no constraint; the load is clamped at 0.
- Protocol assumption: a bank drops req the cycle after its grant because it has moved to its issue state. A req still held that cycle is arbitrated normally; the bench flags it as a bank protocol error.
- At most one grant per cycle; the command reaches the DRAM bus one cycle after the grant.
- A reset asserted mid-operation clears all windows immediately. Any bank in a CHECK state then sees stall=1 until re-arbitrated.

Decomposition:
- Add to the usertype package:
  - arb_cmd_t enum;
  - default timing constants named after the parameters.
- One sub-module, rr_pick: a NUM_BANKS-wide round-robin priority picker.
  - Inputs: eligible mask, rr_ptr.
  - Outputs: found, index.
  - Instantiated once per class (REF, COL, PRE, ACT).
- Timing counters and the FAW ring live in bank_cmd_arbiter.

Test Plan:
- Reset release with init_done=0 and req=8'hFF of ACT -> stall=8'hFF and grant_valid=0 for 10 cycles. Set init_done=1 -> bank 0 granted ACT that same cycle.
- Banks 0–7 each request ACT once, dropping req after their grant -> 8 grants with spacing 4,4,4, then the 5th ACT at cycle t0+20, then 6th–8th at tRRD spacing; grant order 0,1,…,7.
- Bank 2 requests WR granted at cycle t, then bank 5 requests RD from t+1 -> RD granted at t+6, not t+4. Reverse order (RD then WR) -> WR at t+8.
- Same cycle: bank 3 requests REF, bank 1 RD, bank 4 PRE, bank 6 ACT -> grants REF(3), RD(1), PRE(4) in successive cycles. ACT(6) is not granted before REF grant cycle +100.
- rr_ptr=7, then banks 0 and 7 both request PRE -> bank 7 granted first, bank 0 next cycle.
- rst_n pulsed low mid-window (cnt_rrd=3) -> stall=8'hFF during reset. Next ACT is granted the first cycle after release with init_done=1.
